// File: rtl/rand_share_arbiter.sv
// rand_share_arbiter: one 8-bit Fibonacci LFSR shared round-robin among N_REQ
// requesters. Each grant hands out one byte. The LFSR is then stirred MIX_STEPS
// times before the next grant, so no two consumers see overlapping bit windows.
// Optional feature macro: RAND_STATS_EN adds a saturating grant counter (grant_cnt).
module rand_share_arbiter #(
    parameter int          N_REQ        = 4,
    parameter int          MIX_STEPS    = 8,
    parameter logic [7:0]  DEFAULT_SEED = 8'hB8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seed_i,
    input  logic              seed_load,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [7:0]        rand_data,
    output logic              rand_valid,
    output logic              busy
`ifdef RAND_STATS_EN
    ,
    output logic [15:0]       grant_cnt
`endif
);

    localparam int PTR_W = (N_REQ <= 2) ? 1 : $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        MIX   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [7:0]         lfsr_reg, lfsr_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [3:0]         mix_cnt_reg, mix_cnt_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic               rand_valid_reg, rand_valid_next;
    logic [7:0]         rand_data_reg, rand_data_next;

    // Winner search signals
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               win_found;
    logic [PTR_W-1:0]   win_off;
    logic [PTR_W:0]     win_sum;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     ptr_sum;
    logic [PTR_W-1:0]   win_ptr_next;
    logic [N_REQ-1:0]   win_onehot;

    logic [7:0]         seed_eff;
    logic               lfsr_fb;

    // A zero seed would lock the LFSR, so it is replaced by the default seed.
    assign seed_eff = (seed_i == 8'h00) ? DEFAULT_SEED : seed_i;
    assign lfsr_fb  = lfsr_reg[5] ^ lfsr_reg[3] ^ lfsr_reg[2] ^ lfsr_reg[0];

    // Round-robin search: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_dbl   = {req, req};
        req_rot   = N_REQ'(req_dbl >> rr_ptr_reg);
        win_found = 1'b0;
        win_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = PTR_W'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_reg} + {1'b0, win_off};
        if (win_sum >= (PTR_W+1)'(N_REQ)) begin
            win_sum = win_sum - (PTR_W+1)'(N_REQ);
        end
        win_idx = win_sum[PTR_W-1:0];
        ptr_sum = {1'b0, win_idx} + (PTR_W+1)'(1);
        if (ptr_sum >= (PTR_W+1)'(N_REQ)) begin
            ptr_sum = '0;
        end
        win_ptr_next = ptr_sum[PTR_W-1:0];
    end

    // One-hot decode of the winning index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == PTR_W'(gi));
        end
    endgenerate

    // Next-state and registered-output logic for the IDLE/GRANT/MIX sequencer.
    always_comb begin
        state_next      = state_reg;
        lfsr_next       = lfsr_reg;
        rr_ptr_next     = rr_ptr_reg;
        mix_cnt_next    = mix_cnt_reg;
        gnt_next        = '0;
        rand_valid_next = 1'b0;
        rand_data_next  = rand_data_reg;
        unique case (state_reg)
            IDLE: begin
                if (seed_load) begin
                    lfsr_next = seed_eff;
                end else if (win_found) begin
                    gnt_next        = win_onehot;
                    rand_valid_next = 1'b1;
                    rand_data_next  = lfsr_reg;
                    rr_ptr_next     = win_ptr_next;
                    state_next      = GRANT;
                end
            end
            GRANT: begin
                // The grant already went out; a seed load here just skips the mix.
                if (seed_load) begin
                    lfsr_next  = seed_eff;
                    state_next = IDLE;
                end else begin
                    mix_cnt_next = '0;
                    state_next   = MIX;
                end
            end
            MIX: begin
                if (seed_load) begin
                    lfsr_next  = seed_eff;
                    state_next = IDLE;
                end else begin
                    lfsr_next = {lfsr_reg[6:0], lfsr_fb};
                    if (mix_cnt_reg == 4'(MIX_STEPS - 1)) begin
                        mix_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        mix_cnt_next = mix_cnt_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            lfsr_reg       <= DEFAULT_SEED;
            rr_ptr_reg     <= '0;
            mix_cnt_reg    <= '0;
            gnt_reg        <= '0;
            rand_valid_reg <= 1'b0;
            rand_data_reg  <= 8'h00;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            rr_ptr_reg     <= rr_ptr_next;
            mix_cnt_reg    <= mix_cnt_next;
            gnt_reg        <= gnt_next;
            rand_valid_reg <= rand_valid_next;
            rand_data_reg  <= rand_data_next;
        end
    end

    assign gnt        = gnt_reg;
    assign rand_valid = rand_valid_reg;
    assign rand_data  = rand_data_reg;
    assign busy       = (state_reg != IDLE);

`ifdef RAND_STATS_EN
    logic [15:0] grant_cnt_reg;

    // Saturating count of GRANT cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_reg <= 16'h0000;
        end else if (state_reg == GRANT && grant_cnt_reg != 16'hFFFF) begin
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
        end
    end

    assign grant_cnt = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_rand_share_arbiter.sv
// Directed testbench for rand_share_arbiter (default parameters).
module tb_rand_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seed_i = 8'h00;
    logic       seed_load = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [7:0] rand_data;
    logic       rand_valid;
    logic       busy;
`ifdef RAND_STATS_EN
    logic [15:0] grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    rand_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .seed_i     (seed_i),
        .seed_load  (seed_load),
        .req        (req),
        .gnt        (gnt),
        .rand_data  (rand_data),
        .rand_valid (rand_valid),
        .busy       (busy)
`ifdef RAND_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Wait (bounded) for the next grant; check spacing, one-hot value and optionally data.
    task automatic wait_gnt(input string tag, input logic [3:0] exp_gnt, input int exp_cyc,
                            input bit chk_data, input logic [7:0] exp_data);
        int n;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            n = i;
            if (gnt != 4'b0000) break;
        end
        chk({tag, "_gnt"}, 16'(gnt), 16'(exp_gnt));
        chk({tag, "_cyc"}, 16'(n), 16'(exp_cyc));
        if (chk_data) chk({tag, "_data"}, 16'(rand_data), 16'(exp_data));
    endtask

    initial begin
        // ---- 1: reset state and first grant ----
        #1;
        tick(); tick();
        chk("rst_gnt", 16'(gnt), 16'h0);
        chk("rst_valid", 16'(rand_valid), 16'h0);
        chk("rst_data", 16'(rand_data), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk("t1_gnt", 16'(gnt), 16'h4);
        chk("t1_valid", 16'(rand_valid), 16'h1);
        chk("t1_data", 16'(rand_data), 16'hB8);
        chk("t1_busy0", 16'(busy), 16'h1);
        req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_busy_mix", 16'(busy), 16'h1);
        end
        chk("t1_valid_off", 16'(rand_valid), 16'h0);
        tick();
        chk("t1_busy_end", 16'(busy), 16'h0);

        // ---- 2: seed 01, two grants 10 cycles apart ----
        seed_i = 8'h01; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        req = 4'b0001;
        wait_gnt("t2_first", 4'b0001, 1, 1'b1, 8'h01);
        wait_gnt("t2_second", 4'b0001, 10, 1'b1, 8'hC2);
        req = 4'b0000;

        // ---- 3: round robin over all four, then with req[1] dropped ----
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        wait_gnt("t3_a0", 4'b0001, 1, 1'b1, 8'hB8);
        wait_gnt("t3_a1", 4'b0010, 10, 1'b0, 8'h00);
        wait_gnt("t3_a2", 4'b0100, 10, 1'b0, 8'h00);
        wait_gnt("t3_a3", 4'b1000, 10, 1'b0, 8'h00);
        wait_gnt("t3_a4", 4'b0001, 10, 1'b0, 8'h00);
        rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
        req = 4'b1101;
        wait_gnt("t3_b0", 4'b0001, 1, 1'b0, 8'h00);
        wait_gnt("t3_b2", 4'b0100, 10, 1'b0, 8'h00);
        wait_gnt("t3_b3", 4'b1000, 10, 1'b0, 8'h00);
        wait_gnt("t3_b4", 4'b0001, 10, 1'b0, 8'h00);
        req = 4'b0000;

        // ---- 4: zero seed together with a request in IDLE ----
        for (int i = 0; i < 9; i++) tick();
        chk("t4_idle", 16'(busy), 16'h0);
        seed_i = 8'h00; seed_load = 1'b1; req = 4'b0010;
        tick();
        chk("t4_nognt", 16'(gnt), 16'h0);
        chk("t4_nobusy", 16'(busy), 16'h0);
        seed_load = 1'b0;
        tick();
        chk("t4_gnt", 16'(gnt), 16'h2);
        chk("t4_data", 16'(rand_data), 16'hB8);
        req = 4'b0000;

        // ---- 5: seed load in MIX cycle 3 aborts the mix ----
        tick(); tick(); tick();
        chk("t5_inmix", 16'(busy), 16'h1);
        seed_i = 8'h5A; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("t5_abort", 16'(busy), 16'h0);
        req = 4'b1000;
        tick();
        chk("t5_gnt", 16'(gnt), 16'h8);
        chk("t5_data", 16'(rand_data), 16'h5A);
        req = 4'b0000;

        // seed load in GRANT: grant stands, no mix follows
        seed_i = 8'h33; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("t5g_nomix", 16'(busy), 16'h0);
        req = 4'b0001;
        tick();
        chk("t5g_gnt", 16'(gnt), 16'h1);
        chk("t5g_data", 16'(rand_data), 16'h33);
        req = 4'b0000;

        // reset asserted during GRANT
        rst = 1'b1;
        tick();
        chk("t5r_gnt", 16'(gnt), 16'h0);
        chk("t5r_valid", 16'(rand_valid), 16'h0);
        chk("t5r_data", 16'(rand_data), 16'h0);
        chk("t5r_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        tick();

`ifdef RAND_STATS_EN
        // ---- 6: grant counter ----
        chk("t6_zero", grant_cnt, 16'd0);
        req = 4'b0001;
        wait_gnt("t6_g1", 4'b0001, 1, 1'b0, 8'h00);
        wait_gnt("t6_g2", 4'b0001, 10, 1'b0, 8'h00);
        wait_gnt("t6_g3", 4'b0001, 10, 1'b0, 8'h00);
        req = 4'b0000;
        tick();
        chk("t6_three", grant_cnt, 16'd3);
        seed_i = 8'h77; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        chk("t6_seed", grant_cnt, 16'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst", grant_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
